// File: rtl/calc_pkg.sv
// Shared types and display constants for the calculator control unit.
package calc_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4,
    ERR     = 3'd5
  } calc_state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_OR  = 2'd2,
    OP_AND = 2'd3
  } calc_op_t;

  localparam logic [3:0] LEDS_WAIT_A  = 4'b0000;
  localparam logic [3:0] LEDS_WAIT_B  = 4'b0001;
  localparam logic [3:0] LEDS_WAIT_OP = 4'b0011;
  localparam logic [3:0] LEDS_EXEC    = 4'b0111;
  localparam logic [3:0] LEDS_SHOW    = 4'b1111;
  localparam logic [3:0] LEDS_ERR     = 4'b1010;

  function automatic logic [3:0] leds_for_state(input calc_state_t s);
    case (s)
      WAIT_A:  return LEDS_WAIT_A;
      WAIT_B:  return LEDS_WAIT_B;
      WAIT_OP: return LEDS_WAIT_OP;
      EXEC:    return LEDS_EXEC;
      SHOW:    return LEDS_SHOW;
      ERR:     return LEDS_ERR;
      default: return LEDS_WAIT_A;
    endcase
  endfunction

endpackage

// File: rtl/rise_pulse.sv
// One-cycle pulse on the rising edge of an already-debounced level input.
module rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control unit: collects A, B and opcode from switches, runs the
// ALU via a start/done handshake, shows the result and supports undo.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int N       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enter_btn,
  input  logic         undo_btn,
  input  logic [N-1:0] sw,
  input  logic         alu_done,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         alu_start,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  output logic [1:0]   op_code,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic [2:0]   stage,
  output logic [3:0]   stage_leds,
  output logic [N-1:0] display_val,
  output logic         busy,
  output logic         error
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  calc_state_t   state, state_n;
  logic [N-1:0]  op_a_n, op_b_n, result_n;
  logic [1:0]    op_code_n;
  logic [3:0]    flags_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          enter_p, undo_p;

  rise_pulse u_enter (.clk(clk), .rst(rst), .level(enter_btn), .pulse(enter_p));
  rise_pulse u_undo  (.clk(clk), .rst(rst), .level(undo_btn),  .pulse(undo_p));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WAIT_A;
      op_a    <= '0;
      op_b    <= '0;
      op_code <= '0;
      result  <= '0;
      flags   <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      op_a    <= op_a_n;
      op_b    <= op_b_n;
      op_code <= op_code_n;
      result  <= result_n;
      flags   <= flags_n;
      cnt     <= cnt_n;
    end
  end

  // Undo is tested before enter everywhere so a simultaneous press is an undo.
  always_comb begin
    state_n   = state;
    op_a_n    = op_a;
    op_b_n    = op_b;
    op_code_n = op_code;
    result_n  = result;
    flags_n   = flags;
    cnt_n     = cnt;
    alu_start = 1'b0;
    case (state)
      WAIT_A: begin
        if (enter_p && !undo_p) begin
          op_a_n  = sw;
          state_n = WAIT_B;
        end
      end
      WAIT_B: begin
        if (undo_p) begin
          state_n = WAIT_A;
        end else if (enter_p) begin
          op_b_n  = sw;
          state_n = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (undo_p) begin
          state_n = WAIT_B;
        end else if (enter_p) begin
          op_code_n = sw[1:0];
          alu_start = 1'b1;
          cnt_n     = '0;
          state_n   = EXEC;
        end
      end
      EXEC: begin
        // A done arriving on the final counted cycle still completes normally.
        cnt_n = cnt + 1'b1;
        if (alu_done) begin
          result_n = alu_result;
          flags_n  = alu_flags;
          state_n  = SHOW;
        end else if (cnt_n == TIMEOUT_CNT) begin
          state_n = ERR;
        end
      end
      SHOW: begin
        if (undo_p) begin
          state_n = WAIT_OP;
        end else if (enter_p) begin
          op_a_n    = '0;
          op_b_n    = '0;
          op_code_n = '0;
          state_n   = WAIT_A;
        end
      end
      ERR: begin
        if (enter_p || undo_p) begin
          op_a_n    = '0;
          op_b_n    = '0;
          op_code_n = '0;
          result_n  = '0;
          flags_n   = '0;
          cnt_n     = '0;
          state_n   = WAIT_A;
        end
      end
      default: state_n = WAIT_A;
    endcase
  end

  always_comb begin
    display_val = sw;
    case (state)
      EXEC:    display_val = op_b;
      SHOW:    display_val = result;
      ERR:     display_val = '1;
      default: display_val = sw;
    endcase
  end

  assign stage      = state;
  assign stage_leds = leds_for_state(state);
  assign busy       = (state == EXEC);
  assign error      = (state == ERR);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer with hand-computed expectations.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enter_btn = 1'b0;
  logic        undo_btn = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0000;
  logic [3:0]  alu_flags = 4'h0;
  logic        alu_start;
  logic [15:0] op_a, op_b, result, display_val;
  logic [1:0]  op_code;
  logic [3:0]  flags, stage_leds;
  logic [2:0]  stage;
  logic        busy, error;

  int checks = 0;
  int fails = 0;
  int exec_cycles;
  int busy_cnt;
  int start_cnt;

  calc_sequencer #(.N(16), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .enter_btn(enter_btn), .undo_btn(undo_btn), .sw(sw),
    .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
    .alu_start(alu_start), .op_a(op_a), .op_b(op_b), .op_code(op_code),
    .result(result), .flags(flags), .stage(stage), .stage_leds(stage_leds),
    .display_val(display_val), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_enter(input logic [15:0] v);
    sw = v;
    enter_btn = 1'b1;
    step();
    enter_btn = 1'b0;
    step();
  endtask

  task automatic press_undo();
    undo_btn = 1'b1;
    step();
    undo_btn = 1'b0;
    step();
  endtask

  // Enter the opcode from WAIT_OP; leaves the bench in the first EXEC cycle.
  task automatic launch(input logic [1:0] op, input string tag);
    sw = {14'h0, op};
    enter_btn = 1'b1;
    #1;
    check_output({tag, "_start_hi"}, alu_start, 1'b1);
    step();
    enter_btn = 1'b0;
    #1;
    check_output({tag, "_start_lo"}, alu_start, 1'b0);
    check_output({tag, "_busy"}, busy, 1'b1);
  endtask

  // Pulse alu_done during the n-th EXEC cycle, counting busy and start cycles.
  task automatic run_alu(input int n, input logic [15:0] res, input logic [3:0] fl);
    busy_cnt = 0;
    start_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (busy) busy_cnt++;
      if (alu_start) start_cnt++;
      if (i == n - 1) begin
        alu_done = 1'b1;
        alu_result = res;
        alu_flags = fl;
      end
      step();
    end
    alu_done = 1'b0;
    #1;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    sw = 16'h00C3;
    #1;
    check_output("reset_stage", stage, 3'd0);
    check_output("reset_op_a", op_a, 16'h0);
    check_output("reset_result", result, 16'h0);
    check_output("reset_start", alu_start, 1'b0);
    check_output("reset_leds", stage_leds, 4'b0000);
    check_output("wait_a_display", display_val, 16'h00C3);

    // Full pass 5 - 3
    press_enter(16'h0005);
    check_output("pass_stage_b", stage, 3'd1);
    check_output("pass_op_a", op_a, 16'h0005);
    check_output("pass_leds_b", stage_leds, 4'b0001);
    press_enter(16'h0003);
    check_output("pass_stage_op", stage, 3'd2);
    check_output("pass_op_b", op_b, 16'h0003);
    check_output("pass_leds_op", stage_leds, 4'b0011);
    launch(2'd1, "pass");
    check_output("exec_display", display_val, 16'h0003);
    check_output("exec_leds", stage_leds, 4'b0111);
    run_alu(3, 16'h0002, 4'b0000);
    check_output("pass_busy_cycles", busy_cnt, 3);
    check_output("pass_extra_starts", start_cnt, 0);
    check_output("pass_stage_show", stage, 3'd4);
    check_output("pass_display", display_val, 16'h0002);
    check_output("pass_leds_show", stage_leds, 4'b1111);
    check_output("pass_op_code", op_code, 2'd1);
    check_output("pass_busy_off", busy, 1'b0);

    // SHOW enter clears operands
    press_enter(16'h0000);
    check_output("show_enter_stage", stage, 3'd0);
    check_output("show_enter_op_a", op_a, 16'h0);
    check_output("show_enter_op_b", op_b, 16'h0);
    check_output("show_enter_result_kept", result, 16'h0002);

    // Held enter: one advance, first sample only
    sw = 16'h0007;
    enter_btn = 1'b1;
    step();
    sw = 16'h0009;
    for (int i = 0; i < 19; i++) step();
    check_output("held_stage", stage, 3'd1);
    check_output("held_op_a", op_a, 16'h0007);
    enter_btn = 1'b0;
    step();

    // Undo from WAIT_OP keeps op_a
    press_enter(16'h0003);
    check_output("undo_pre_stage", stage, 3'd2);
    press_undo();
    check_output("undo_op_stage", stage, 3'd1);
    check_output("undo_op_a", op_a, 16'h0007);

    // Simultaneous enter and undo in WAIT_B
    sw = 16'h0055;
    enter_btn = 1'b1;
    undo_btn = 1'b1;
    step();
    enter_btn = 1'b0;
    undo_btn = 1'b0;
    step();
    check_output("both_stage", stage, 3'd0);
    check_output("both_op_b", op_b, 16'h0003);
    check_output("both_op_a", op_a, 16'h0007);
    press_undo();
    check_output("undo_in_wait_a", stage, 3'd0);

    // Undo from SHOW then re-enter ADD
    press_enter(16'h0005);
    press_enter(16'h0003);
    launch(2'd1, "redo_sub");
    run_alu(2, 16'h0002, 4'b0000);
    check_output("redo_show", stage, 3'd4);
    press_undo();
    check_output("show_undo_stage", stage, 3'd2);
    launch(2'd0, "redo_add");
    run_alu(1, 16'h0008, 4'b0000);
    check_output("add_stage", stage, 3'd4);
    check_output("add_result", result, 16'h0008);
    check_output("add_op_code", op_code, 2'd0);

    // alu_done outside EXEC is ignored
    alu_done = 1'b1;
    alu_result = 16'h1234;
    alu_flags = 4'b1111;
    step();
    alu_done = 1'b0;
    #1;
    check_output("stray_done_result", result, 16'h0008);
    check_output("stray_done_flags", flags, 4'b0000);

    // Done on the last allowed cycle still wins over timeout
    press_enter(16'h0000);
    press_enter(16'h0005);
    press_enter(16'h0003);
    launch(2'd2, "edge");
    run_alu(255, 16'h00AA, 4'b0010);
    check_output("edge_busy_cycles", busy_cnt, 255);
    check_output("edge_stage", stage, 3'd4);
    check_output("edge_result", result, 16'h00AA);
    check_output("edge_flags", flags, 4'b0010);

    // Timeout into ERR
    press_enter(16'h0000);
    press_enter(16'h0001);
    press_enter(16'h0002);
    launch(2'd3, "tmo");
    exec_cycles = 1;
    while (busy && exec_cycles < 400) begin
      step();
      if (busy) exec_cycles++;
    end
    check_output("tmo_exec_cycles", exec_cycles, 255);
    check_output("tmo_stage", stage, 3'd5);
    check_output("tmo_error", error, 1'b1);
    check_output("tmo_display", display_val, 16'hFFFF);
    check_output("tmo_leds", stage_leds, 4'b1010);
    press_enter(16'h0000);
    check_output("err_clr_stage", stage, 3'd0);
    check_output("err_clr_op_a", op_a, 16'h0);
    check_output("err_clr_op_b", op_b, 16'h0);
    check_output("err_clr_op_code", op_code, 2'd0);
    check_output("err_clr_result", result, 16'h0);
    check_output("err_clr_flags", flags, 4'h0);

    // Reset mid-EXEC, late done ignored
    press_enter(16'h0005);
    press_enter(16'h0003);
    launch(2'd0, "rst_exec");
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_output("rst_exec_stage", stage, 3'd0);
    alu_done = 1'b1;
    alu_result = 16'h0077;
    step();
    alu_done = 1'b0;
    #1;
    check_output("rst_late_stage", stage, 3'd0);
    check_output("rst_late_result", result, 16'h0);
    check_output("rst_late_op_a", op_a, 16'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
